// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store ports.
// Round-robin tie-break, one outstanding read, read-response timeout with sticky error.
module mem_port_arbiter #(
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter int             TIMEOUT  = 16,
  parameter logic [DW-1:0]  ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic          ptr;    // 1 = data port wins the next tie
  logic          owner;  // 1 = data port owns the outstanding read
  logic [TW-1:0] timer;
  logic          idle;
  logic          pick_d, pick_if;
  logic          rsp_fire;
  logic [DW-1:0] rsp_data;

  assign pick_d  = d_req  & (~if_req | ptr);
  assign pick_if = if_req & (~d_req  | ~ptr);

  // Grants are gated by reset so nothing reaches memory while reset is held.
  assign idle      = (state == IDLE) & ~reset;
  assign d_gnt     = idle & pick_d;
  assign if_gnt    = idle & pick_if;
  assign mem_valid = d_gnt | if_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr : if_addr;
  assign mem_wdata = d_wdata;

  // Real data wins over a timeout landing in the same cycle.
  assign rsp_fire = mem_rvalid | (timer == T_LAST);
  assign rsp_data = mem_rvalid ? mem_rdata : ERR_DATA;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b1;
      owner     <= 1'b0;
      timer     <= '0;
      err       <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_rvalid) err <= 1'b1;
          if (mem_valid) begin
            ptr <= if_gnt;
            if (!mem_we) begin
              owner <= d_gnt;
              timer <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (rsp_fire) begin
            if (!mem_rvalid) err <= 1'b1;
            if (owner) begin
              d_rdata  <= rsp_data;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= rsp_data;
              if_rvalid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed reads/writes, a latency-programmable
// memory model, and a monitor that checks every rvalid against queued expectations.
module tb_mem_port_arbiter;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, d_gnt, if_rvalid, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_valid, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit is_d; logic [31:0] data; int cyc;} exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model controls (written by stimulus only)
  int  mem_lat  = 1;
  bit  mem_mute = 1'b0;
  int  inj_req  = 0;

  initial begin : memory
    logic [31:0] mem_arr [logic [31:0]];
    int          rsp_cnt = 0;
    logic [31:0] rsp_data = '0;
    int          inj_ack = 0;
    mem_arr[32'h4]  = 32'h0050_0093;
    mem_arr[32'h8]  = 32'h0000_0013;
    mem_arr[32'h20] = 32'hCAFE_0020;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (mem_valid && mem_we) mem_arr[mem_addr] = mem_wdata;
      if (mem_valid && !mem_we && !mem_mute) begin
        rsp_cnt  = mem_lat;
        rsp_data = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : (mem_addr ^ 32'h1234_5678);
      end
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rsp_data;
        end
      end
      if (inj_req != inj_ack) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_0BAD;
        inj_ack++;
      end
    end
  end

  task automatic check_rsp(input bit is_d, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      chk(is_d ? "unexpected_d_rvalid" : "unexpected_if_rvalid", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("rsp_port", 32'(is_d), 32'(e.is_d));
      chk("rsp_data", data, e.data);
      chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  initial begin : monitor
    bit outstanding = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        outstanding = 1'b0;
        chk("reset_outputs", {25'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_valid, |if_rdata, |d_rdata}, 32'd0);
      end else begin
        if (if_rvalid) check_rsp(1'b0, if_rdata);
        if (d_rvalid)  check_rsp(1'b1, d_rdata);
        if (if_rvalid || d_rvalid) outstanding = 1'b0;
        if (if_gnt || d_gnt) begin
          chk("gnt_while_wait", 32'(outstanding), 32'd0);
          chk("double_gnt", 32'(if_gnt && d_gnt), 32'd0);
          if (if_gnt || !d_we) outstanding = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // Issue one read, wait for its grant and queue the expected response.
  task automatic read_req(input bit is_d, input logic [31:0] addr, input int lat, input bit mute,
                          input logic [31:0] exp_data, input int exp_lat);
    bit got = 1'b0;
    mem_lat = lat; mem_mute = mute;
    if (is_d) begin d_req = 1'b1; d_we = 1'b0; d_addr = addr; end
    else      begin if_req = 1'b1; if_addr = addr; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_d ? d_gnt : if_gnt) begin
        got = 1'b1;
        sb.push_back('{is_d, exp_data, cyc + exp_lat});
        break;
      end
    end
    chk("read_gnt", 32'(got), 32'd1);
    step();
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    step();
  endtask

  initial begin : stimulus
    bit          gp [3];
    int          gc [3];
    int          ng;
    reset = 1'b1;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h4; d_addr = 32'h10; d_wdata = '0;
    step(); step(); step();
    if_req = 1'b0; d_req = 1'b0;
    step();
    reset = 1'b0;
    chk("err_after_reset", 32'(err), 32'd0);
    step();

    // T1: write granted combinationally, back-to-back write next cycle
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("t1_d_gnt", 32'(d_gnt), 32'd1);
    chk("t1_if_gnt", 32'(if_gnt), 32'd0);
    chk("t1_mem_cmd", {30'd0, mem_valid, mem_we}, 32'd3);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    step();
    d_addr = 32'h14; d_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("t1_b2b_gnt", 32'(d_gnt), 32'd1);
    chk("t1_b2b_addr", mem_addr, 32'h14);
    step();
    d_req = 1'b0; d_we = 1'b0;

    // Read back the written word, latency 1 -> rvalid 2 cycles after gnt
    read_req(1'b1, 32'h10, 1, 1'b0, 32'hA5A5_A5A5, 2);
    wait_drain();
    // T2: fetch, memory latency 2 -> rvalid 3 cycles after gnt
    read_req(1'b0, 32'h4, 2, 1'b0, 32'h0050_0093, 3);
    wait_drain();
    // Response lands exactly on the timeout cycle: real data, no error
    read_req(1'b1, 32'h40, TO, 1'b0, 32'h1234_5638, TO + 1);
    wait_drain();
    chk("boundary_no_err", 32'(err), 32'd0);
    // T4: memory silent -> ERR_DATA TIMEOUT cycles after entering WAIT
    read_req(1'b1, 32'h30, 1, 1'b1, 32'hDEAD_BEEF, TO + 1);
    wait_drain();
    mem_mute = 1'b0;
    chk("t4_err", 32'(err), 32'd1);

    // T3: both ports requesting from reset, latency 1
    reset = 1'b1;
    mem_lat = 1;
    d_we = 1'b0; d_addr = 32'h20; if_addr = 32'h8;
    if_req = 1'b1; d_req = 1'b1;
    step(); step();
    reset = 1'b0;
    ng = 0;
    for (int i = 0; i < 30 && ng < 3; i++) begin
      @(negedge clk);
      if (d_gnt || if_gnt) begin
        gp[ng] = d_gnt;
        gc[ng] = cyc;
        sb.push_back('{d_gnt, d_gnt ? 32'hCAFE_0020 : 32'h0000_0013, cyc + 2});
        ng++;
      end
    end
    step();
    if_req = 1'b0; d_req = 1'b0;
    chk("t3_grant_count", 32'(ng), 32'd3);
    chk("t3_grant_order", {29'd0, gp[0], gp[1], gp[2]}, 32'b101);
    chk("t3_gap1", 32'(gc[1] - gc[0]), 32'd2);
    chk("t3_gap2", 32'(gc[2] - gc[1]), 32'd2);
    wait_drain();
    chk("t3_no_err", 32'(err), 32'd0);

    // T5: spurious mem_rvalid in IDLE -> sticky err, no rvalid
    do_reset();
    chk("t5_err_clear", 32'(err), 32'd0);
    inj_req++;
    step(); step(); step();
    chk("t5_err_set", 32'(err), 32'd1);
    repeat (5) step();
    chk("t5_err_sticky", 32'(err), 32'd1);

    // T6: reset one cycle after a fetch grant; late response is spurious
    do_reset();
    chk("t6_err_clear", 32'(err), 32'd0);
    mem_lat = 5; mem_mute = 1'b0;
    if_req = 1'b1; if_addr = 32'h4;
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_gnt) begin ng = 1; break; end
    end
    chk("t6_gnt", 32'(ng), 32'd1);
    step();
    if_req = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (6) step();
    chk("t6_err_spurious", 32'(err), 32'd1);
    chk("t6_if_rdata", if_rdata, 32'd0);
    chk("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
